// File: rtl/vc_merge_pkg.sv
// ---------------------------------------------------------------------------
// vc_merge_pkg
//   Shared definitions for the four-input round-robin stream merge.
//   - NUM_IN / SRC_W : number of merged inputs and width of a source index
//   - lock_state_e   : packet-lock FSM encoding (used only when the design is
//                      built with VC_RR_MERGE4_LOCK_EN)
//   - idx_to_1hot    : 2-bit index to 4-bit one-hot conversion
// ---------------------------------------------------------------------------
package vc_merge_pkg;

  localparam int NUM_IN = 4;
  localparam int SRC_W  = 2;

  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  function automatic logic [NUM_IN-1:0] idx_to_1hot(input logic [SRC_W-1:0] idx);
    logic [NUM_IN-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/vc_rr_arb4.sv
// ---------------------------------------------------------------------------
// vc_rr_arb4
//   Four-way round-robin arbiter. Owns the 2-bit priority pointer, performs the
//   combinational search starting at the pointer and advances the pointer to
//   one past the winner when strobed.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-low; pointer returns to 0 (input 0 first)
//   req        : per-input request
//   en         : pointer update strobe (a grant was consumed this cycle)
//   hold_grant : force the grant to hold_idx regardless of req
//   hold_idx   : index forced while hold_grant is set
//   grant_1hot : one-hot grant, all zeros when nothing is granted
//   grant_idx  : binary index of the grant (equals the pointer when no grant)
// ---------------------------------------------------------------------------
module vc_rr_arb4
  import vc_merge_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic              en,
  input  logic              hold_grant,
  input  logic [SRC_W-1:0]  hold_idx,
  output logic [NUM_IN-1:0] grant_1hot,
  output logic [SRC_W-1:0]  grant_idx
);

  logic [SRC_W-1:0] ptr_q;
  logic [SRC_W-1:0] ptr_d;
  logic [SRC_W-1:0] cand;
  logic             found;

  // Scan ptr, ptr+1, ... with natural 2-bit wrap; the first requester wins.
  always_comb begin
    grant_idx = ptr_q;
    found     = 1'b0;
    cand      = ptr_q;
    for (int i = 0; i < NUM_IN; i++) begin
      cand = ptr_q + SRC_W'(i);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
    // A locked packet keeps its source even through valid gaps.
    if (hold_grant) begin
      grant_idx = hold_idx;
      found     = 1'b1;
    end
    grant_1hot = found ? idx_to_1hot(grant_idx) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = grant_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vc_rr_merge4.sv
// ---------------------------------------------------------------------------
// vc_rr_merge4
//   Four-input round-robin stream merge with a single registered output stage.
//   Each accepted message is tagged with its source index. grant_1hot is the
//   live grant and can drive a downstream one-hot mux select directly.
//
// Handshake: a transfer happens on a port when its val and rdy are both 1 at
//   a rising clock edge. rdy never depends on message contents; in_rdy depends
//   combinationally on in_val and out_rdy, and is forced low during reset.
//
// Build option: define VC_RR_MERGE4_LOCK_EN to keep multi-beat packets
//   contiguous. This adds the in_last input and the lock_state debug output.
//
// Ports:
//   clk                    : clock, rising edge
//   reset                  : synchronous, active-low
//   in_val / in_rdy        : per-input valid / ready (in_rdy at most one-hot)
//   in0_msg .. in3_msg     : input messages, W bits
//   in_last    (LOCK only) : per-input end-of-packet marker
//   lock_state (LOCK only) : lock FSM state, for observation
//   out_val / out_rdy      : output stream valid / ready
//   out_msg                : registered message
//   out_src                : index of the input that supplied out_msg
//   grant_1hot             : this cycle's grant, all zeros when none
// ---------------------------------------------------------------------------
module vc_rr_merge4
  import vc_merge_pkg::*;
#(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] in_val,
  output logic [NUM_IN-1:0] in_rdy,
  input  logic [W-1:0]      in0_msg,
  input  logic [W-1:0]      in1_msg,
  input  logic [W-1:0]      in2_msg,
  input  logic [W-1:0]      in3_msg,
`ifdef VC_RR_MERGE4_LOCK_EN
  input  logic [NUM_IN-1:0] in_last,
  output lock_state_e       lock_state,
`endif
  output logic              out_val,
  input  logic              out_rdy,
  output logic [W-1:0]      out_msg,
  output logic [SRC_W-1:0]  out_src,
  output logic [NUM_IN-1:0] grant_1hot
);

  logic             out_val_q, out_val_d;
  logic [W-1:0]     out_msg_q, out_msg_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;

  logic             can_load;
  logic             xfer;
  logic [SRC_W-1:0] grant_idx;
  logic [W-1:0]     sel_msg;
  logic             ptr_en;
  logic             hold_grant;
  logic [SRC_W-1:0] hold_idx;

  vc_rr_arb4 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (in_val),
    .en         (ptr_en),
    .hold_grant (hold_grant),
    .hold_idx   (hold_idx),
    .grant_1hot (grant_1hot),
    .grant_idx  (grant_idx)
  );

  // The register takes a new message when empty or draining this same edge.
  assign can_load = !out_val_q || out_rdy;
  // Gating with reset keeps handshakes in the reset cycle from completing.
  assign in_rdy   = grant_1hot & {NUM_IN{can_load & reset}};
  assign xfer     = |(in_val & in_rdy);

  always_comb begin
    sel_msg = in0_msg;
    case (grant_idx)
      2'd0:    sel_msg = in0_msg;
      2'd1:    sel_msg = in1_msg;
      2'd2:    sel_msg = in2_msg;
      default: sel_msg = in3_msg;
    endcase
  end

`ifdef VC_RR_MERGE4_LOCK_EN
  lock_state_e      lock_state_q, lock_state_d;
  logic [SRC_W-1:0] lock_idx_q, lock_idx_d;

  always_comb begin
    lock_state_d = lock_state_q;
    lock_idx_d   = lock_idx_q;
    case (lock_state_q)
      LOCK_IDLE: begin
        if (xfer && !in_last[grant_idx]) begin
          lock_state_d = LOCK_LOCKED;
          lock_idx_d   = grant_idx;
        end
      end
      LOCK_LOCKED: begin
        if (xfer && in_last[grant_idx]) begin
          lock_state_d = LOCK_IDLE;
        end
      end
      default: lock_state_d = LOCK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_state_q <= LOCK_IDLE;
      lock_idx_q   <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_idx_q   <= lock_idx_d;
    end
  end

  assign hold_grant = (lock_state_q == LOCK_LOCKED);
  assign hold_idx   = lock_idx_q;
  // Fairness is per packet: the pointer only moves on a closing beat.
  assign ptr_en     = xfer && in_last[grant_idx];
  assign lock_state = lock_state_q;
`else
  assign hold_grant = 1'b0;
  assign hold_idx   = '0;
  assign ptr_en     = xfer;
`endif

  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_src_d = out_src_q;
    if (xfer) begin
      out_val_d = 1'b1;
      out_msg_d = sel_msg;
      out_src_d = grant_idx;
    end else if (out_val_q && out_rdy) begin
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_src_q <= '0;
    end else begin
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_src_q <= out_src_d;
    end
  end

  assign out_val = out_val_q;
  assign out_msg = out_msg_q;
  assign out_src = out_src_q;

endmodule
